// File: rtl/fft_pkg.sv
// Shared types and constants for the 4-point FFT core and its frame loader.
package fft_pkg;

  localparam int FFT_N  = 4;
  localparam int CPLX_W = 32;
  localparam int HALF_W = CPLX_W / 2;

  // Packed complex sample: real half on top, imaginary half below, each Q1.(HALF_W-1).
  typedef struct packed {
    logic signed [HALF_W-1:0] re;
    logic signed [HALF_W-1:0] im;
  } cplx_t;

  typedef cplx_t [0:FFT_N-1] frame_t;

  typedef enum logic [1:0] {
    FLUSH = 2'd0,
    IDLE  = 2'd1,
    RUN   = 2'd2,
    CLEAR = 2'd3
  } loader_state_e;

  // Twiddles for N=4: W^0 = 1 (saturated to max positive), W^1 = -j.
  localparam cplx_t W4_0 = '{re: 16'sh7FFF, im: 16'sh0000};
  localparam cplx_t W4_1 = '{re: 16'sh0000, im: 16'sh8000};

endpackage

// File: rtl/fft_frame_fill.sv
// Fill buffer: packs the valid/ready sample stream into one 4-sample frame
// and raises pending until the engine takes it.
module fft_frame_fill
  import fft_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          in_valid_i,
  input  logic [WIDTH-1:0]              in_data_i,
  input  logic                          eng_idle_i,
  output logic                          in_ready_o,
  output logic                          take_o,
  output logic [0:FFT_N-1][WIDTH-1:0]   fill_o
);

  logic [1:0]                        idx_q, idx_d;
  logic                              pending_q, pending_d;
  logic [0:FFT_N-1][WIDTH-1:0]       fill_q, fill_d;
  logic                              wr;

  // A full frame blocks further input until the engine copies it out.
  assign in_ready_o = !pending_q;
  assign wr         = in_valid_i && in_ready_o;
  assign take_o     = pending_q && eng_idle_i;
  assign fill_o     = fill_q;

  // Next-state: write the indexed slot, wrap after the last slot and mark the frame pending.
  always_comb begin
    idx_d     = idx_q;
    pending_d = pending_q;
    fill_d    = fill_q;
    if (wr) begin
      fill_d[idx_q] = in_data_i;
      idx_d         = idx_q + 2'd1;
      if (idx_q == 2'(FFT_N - 1)) pending_d = 1'b1;
    end
    // take and wr never coincide: take needs pending, wr needs !pending.
    if (take_o) pending_d = 1'b0;
  end

  // State registers; reset drops any partial or pending frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q     <= '0;
      pending_q <= 1'b0;
      fill_q    <= '0;
    end else begin
      idx_q     <= idx_d;
      pending_q <= pending_d;
      fill_q    <= fill_d;
    end
  end

endmodule

// File: rtl/fft_frame_loader.sv
// Frame loader for the 4-point FFT core: feeds frames to the core, waits for
// done, captures the result and clears the core. The next frame fills while
// the current one is transformed.
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic [0:FFT_N-1][WIDTH-1:0]   fft_f,
  output logic                          fft_start,
  output logic                          fft_clear,
  input  logic [0:FFT_N-1][WIDTH-1:0]   fft_F,
  input  logic                          fft_done,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [0:FFT_N-1][WIDTH-1:0]   out_data,
  output logic                          busy
);

  loader_state_e                     state_q;
  logic [1:0]                        flush_cnt_q;
  logic [0:FFT_N-1][WIDTH-1:0]       fft_f_q;
  logic [0:FFT_N-1][WIDTH-1:0]       out_data_q;
  logic                              out_valid_q;
  logic                              take;
  logic [0:FFT_N-1][WIDTH-1:0]       fill;
  logic                              load;

  fft_frame_fill #(.WIDTH(WIDTH)) u_fill (
    .clk_i      (clock),
    .rst_i      (reset),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .eng_idle_i (state_q == IDLE),
    .in_ready_o (in_ready),
    .take_o     (take),
    .fill_o     (fill)
  );

  // Capture the result only when the output slot is free or being drained this cycle.
  assign load = (state_q == RUN) && fft_done && (!out_valid_q || out_ready);

  assign fft_f     = fft_f_q;
  assign fft_start = (state_q == RUN);
  assign fft_clear = reset || (state_q == FLUSH) || (state_q == CLEAR);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE);

  // Engine FSM plus frame and output registers. FLUSH holds the core in reset
  // long enough to walk it back to RESET from any state it was left in.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= FLUSH;
      flush_cnt_q <= 2'd2;
      fft_f_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // Pop clears the slot; a reload on the same edge overrides it below.
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        FLUSH: begin
          flush_cnt_q <= flush_cnt_q - 2'd1;
          if (flush_cnt_q <= 2'd1) state_q <= IDLE;
        end
        IDLE: begin
          if (take) begin
            fft_f_q <= fill;
            state_q <= RUN;
          end
        end
        RUN: begin
          // With the slot full the core simply sits in DONE until we can take the result.
          if (load) begin
            out_data_q  <= fft_F;
            out_valid_q <= 1'b1;
            state_q     <= CLEAR;
          end
        end
        CLEAR: state_q <= IDLE;
        default: state_q <= FLUSH;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader with a behavioural 4-point core stub (F[k] = f[k] + k on the real half).
module tb_fft_frame_loader;
  import fft_pkg::*;

  localparam int W = 32;
  typedef logic [0:FFT_N-1][W-1:0] frm_t;

  logic clock = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [W-1:0] in_data = '0;
  frm_t fft_f, fft_F, out_data;
  logic fft_start, fft_clear, fft_done, out_valid, out_ready = 1'b0, busy;

  int checks = 0, errors = 0;
  int cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  fft_frame_loader #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .fft_f(fft_f), .fft_start(fft_start), .fft_clear(fft_clear),
    .fft_F(fft_F), .fft_done(fft_done), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  function automatic logic [W-1:0] add_re(input logic [W-1:0] x, input int k);
    cplx_t c;
    c = x;
    c.re = c.re + 16'(k);
    return c;
  endfunction

  function automatic frm_t xform(input frm_t f);
    frm_t r;
    for (int k = 0; k < FFT_N; k++) r[k] = add_re(f[k], k);
    return r;
  endfunction

  function automatic logic [W-1:0] re_only(input int v);
    return {16'(v), 16'h0000};
  endfunction

  function automatic logic [W-1:0] rs();
    return {16'($urandom), 16'($urandom)};
  endfunction

  // Core stub: RESET(0) -> STAGE1 -> STAGE2 -> DONE(3), held in DONE until cleared.
  logic [1:0] cst = 2'd0;
  logic done_force = 1'b0;
  always @(posedge clock) begin
    if (fft_clear) cst <= 2'd0;
    else case (cst)
      2'd0: if (fft_start) cst <= 2'd1;
      2'd1: cst <= 2'd2;
      2'd2: cst <= 2'd3;
      default: cst <= 2'd3;
    endcase
  end
  assign fft_done = (cst == 2'd3) || done_force;
  always_comb begin
    fft_F = '0;
    for (int k = 0; k < FFT_N; k++) fft_F[k] = add_re(fft_f[k], k);
  end

  // Reference model: accepted samples grouped by four, transformed, delivered in order.
  logic [W-1:0] part[$];
  frm_t expq[$];
  frm_t mf, mexp;
  int pops = 0;
  int pop_cyc[$];
  always @(negedge clock) begin
    if (reset) begin
      part.delete();
      expq.delete();
    end else begin
      if (in_valid && in_ready) begin
        part.push_back(in_data);
        if (part.size() == FFT_N) begin
          for (int k = 0; k < FFT_N; k++) mf[k] = part[k];
          expq.push_back(xform(mf));
          part.delete();
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        assert (expq.size() != 0) else begin
          errors++;
          $error("FAIL sb_unexpected_frame observed=%h expected=none", out_data);
        end
        if (expq.size() != 0) begin
          mexp = expq.pop_front();
          checks++;
          assert (out_data === mexp) else begin
            errors++;
            $error("FAIL sb_frame observed=%h expected=%h", out_data, mexp);
          end
          pops++;
          pop_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offer one sample and hold it until accepted (bounded).
  task automatic send(input logic [W-1:0] d);
    int n;
    logic hs;
    in_valid = 1'b1;
    in_data  = d;
    for (n = 0; n < 200; n++) begin
      hs = in_ready && !reset;
      tick();
      if (hs) break;
    end
    if (n >= 200) chk("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_out_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    chk(tag, out_valid, 1'b1);
  endtask

  frm_t e, ea, eb;
  frm_t t4s;
  int p0, n, nstart;
  logic done_last, sender_done;

  initial begin
    // T1: reset and flush
    tick();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_start", fft_start, 1'b0);
    chk("rst_clear", fft_clear, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_out_data", out_data, '0);
    chk("rst_fft_f", fft_f, '0);
    tick();
    chk("rst_clear2", fft_clear, 1'b1);
    reset = 1'b0;
    #1;
    chk("flush_clear_a", fft_clear, 1'b1);
    chk("flush_start", fft_start, 1'b0);
    tick();
    chk("flush_clear_b", fft_clear, 1'b1);
    chk("flush_out_valid", out_valid, 1'b0);
    tick();
    chk("flush_done_clear", fft_clear, 1'b0);
    chk("flush_done_busy", busy, 1'b0);

    // fft_done outside RUN has no effect
    done_force = 1'b1;
    tick();
    done_force = 1'b0;
    chk("stray_done_valid", out_valid, 1'b0);
    chk("stray_done_busy", busy, 1'b0);

    // T2: single frame 1,2,3,4
    for (int i = 0; i < 4; i++) send(re_only(i + 1));
    in_valid = 1'b0;
    chk("t2_pending_ready", in_ready, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) e[k] = re_only(k + 1);
    chk("t2_fft_f", fft_f, e);
    chk("t2_ready_back", in_ready, 1'b1);
    nstart = 0;
    done_last = 1'b0;
    while (fft_start && nstart < 20) begin
      done_last = fft_done;
      nstart++;
      tick();
    end
    chk("t2_start_cycles", 32'(nstart), 32'd4);
    chk("t2_done_last_run", done_last, 1'b1);
    chk("t2_out_valid", out_valid, 1'b1);
    for (int k = 0; k < 4; k++) e[k] = re_only(2 * k + 1);
    chk("t2_out_data", out_data, e);
    chk("t2_clear_on", fft_clear, 1'b1);
    tick();
    chk("t2_clear_off", fft_clear, 1'b0);
    chk("t2_hold_valid", out_valid, 1'b1);
    chk("t2_hold_data", out_data, e);
    out_ready = 1'b1;
    tick();
    chk("t2_popped", out_valid, 1'b0);

    // T3: streaming 0..11 with free output
    p0 = pops;
    pop_cyc.delete();
    for (int i = 0; i < 12; i++) send(re_only(i));
    in_valid = 1'b0;
    n = 0;
    while (pops < p0 + 3 && n < 100) begin tick(); n++; end
    chk("t3_frames", 32'(pops - p0), 32'd3);
    if (pop_cyc.size() >= 3) begin
      chk("t3_spacing_1", 32'(pop_cyc[1] - pop_cyc[0]), 32'd6);
      chk("t3_spacing_2", 32'(pop_cyc[2] - pop_cyc[1]), 32'd6);
    end

    // T4: output backpressure with 12 random samples offered
    out_ready = 1'b0;
    p0 = pops;
    sender_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          logic [W-1:0] s;
          s = rs();
          if (i < 4) t4s[i] = s;
          send(s);
        end
        in_valid = 1'b0;
        sender_done = 1'b1;
      end
    join_none
    repeat (20) tick();
    chk("t4_held_valid", out_valid, 1'b1);
    chk("t4_held_data", out_data, xform(t4s));
    chk("t4_run_start", fft_start, 1'b1);
    chk("t4_run_done", fft_done, 1'b1);
    chk("t4_stalled", in_ready, 1'b0);
    out_ready = 1'b1;
    n = 0;
    while ((!sender_done || pops < p0 + 3) && n < 200) begin tick(); n++; end
    chk("t4_frames", 32'(pops - p0), 32'd3);

    // T5: pop and reload on the same edge
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin ea[k] = rs(); send(ea[k]); end
    in_valid = 1'b0;
    wait_out_valid("t5_a_valid");
    for (int k = 0; k < 4; k++) begin eb[k] = rs(); send(eb[k]); end
    in_valid = 1'b0;
    n = 0;
    while (!fft_done && n < 50) begin tick(); n++; end
    chk("t5_done_seen", fft_done, 1'b1);
    chk("t5_slot_full", out_valid, 1'b1);
    chk("t5_a_data", out_data, xform(ea));
    out_ready = 1'b1;
    tick();
    chk("t5_reload_valid", out_valid, 1'b1);
    chk("t5_reload_data", out_data, xform(eb));
    tick();
    chk("t5_drained", out_valid, 1'b0);

    // T6: reset while in RUN with a partial next fill
    for (int k = 0; k < 4; k++) send(rs());
    in_valid = 1'b0;
    n = 0;
    while (!fft_start && n < 50) begin tick(); n++; end
    send(rs());
    send(rs());
    in_valid = 1'b0;
    chk("t6_in_run", fft_start, 1'b1);
    reset = 1'b1;
    tick();
    chk("t6_rst_ready", in_ready, 1'b1);
    chk("t6_rst_valid", out_valid, 1'b0);
    chk("t6_rst_clear", fft_clear, 1'b1);
    reset = 1'b0;
    #1;
    chk("t6_flush_a", fft_clear, 1'b1);
    tick();
    chk("t6_flush_b", fft_clear, 1'b1);
    tick();
    chk("t6_flush_end", fft_clear, 1'b0);
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(re_only(9));
    in_valid = 1'b0;
    wait_out_valid("t6_valid");
    for (int k = 0; k < 4; k++) e[k] = re_only(9 + k);
    chk("t6_out_data", out_data, e);
    out_ready = 1'b1;
    tick();

    // T7: random gaps and random output readiness
    p0 = pops;
    sender_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          in_valid = 1'b0;
          repeat ($urandom_range(0, 2)) tick();
          send(rs());
        end
        in_valid = 1'b0;
        sender_done = 1'b1;
      end
    join_none
    n = 0;
    while ((!sender_done || pops < p0 + 6) && n < 800) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    out_ready = 1'b1;
    chk("t7_frames", 32'(pops - p0), 32'd6);
    chk("t7_model_empty", 32'(expq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
